// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that shares one combinational ALU between NUM_REQ requesters.
// Optional macro ALU_PERF_EN adds a saturating 16-bit completed-operation counter (perf_ops).
module alu_rr_sched #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]   req_sel,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_sel,
    input  logic [WIDTH-1:0]       alu_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data
`ifdef ALU_PERF_EN
    ,
    output logic [15:0]            perf_ops
`endif
);

    localparam int CW = IDW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, next_state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic [IDW:0]   cand;

    // Scan requesters starting at rr_ptr with wrap-around; the first valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NUM_REQ))
                cand = cand - CW'(NUM_REQ);
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (!rst && grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    next_state           = EXEC;
                end
            end
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // ALU operands stay at their last granted values outside IDLE grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        alu_a   <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                        alu_b   <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                        alu_sel <= req_sel[int'(grant_idx)*3 +: 3];
                        rsp_id  <= grant_idx;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_out;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            perf_ops <= '0;
        else if (rsp_valid && rsp_ready && perf_ops != 16'hFFFF)
            perf_ops <= perf_ops + 16'd1;
    end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed self-checking bench for alu_rr_sched with a small combinational ALU model.
// Define ALU_PERF_EN to also exercise the perf_ops counter.
module tb_alu_rr_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
`ifdef ALU_PERF_EN
    logic [15:0] perf_ops;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    alu_rr_sched #(.WIDTH(8), .NUM_REQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef ALU_PERF_EN
        ,
        .perf_ops  (perf_ops)
`endif
    );

    // Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl1, 6 shr1, 7 not a.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = alu_a ^ alu_b;
            3'd5:    alu_out = alu_a << 1;
            3'd6:    alu_out = alu_a >> 1;
            default: alu_out = ~alu_a;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        req_a[id*8 +: 8]   = a;
        req_b[id*8 +: 8]   = b;
        req_sel[id*3 +: 3] = sel;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        set_op(0, 8'd10, 8'd3, 3'd1);
        repeat (2) @(negedge clk);
        #1;
        n_compared++; if (req_ready !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_compared++; if (alu_a !== 8'd0 || alu_b !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_alu_ab: got %0d/%0d expected 0/0", alu_a, alu_b); end
        n_compared++; if (alu_sel !== 3'd0) begin n_mismatched++; $display("[TB] FAIL reset_alu_sel: got %0d expected 0", alu_sel); end
        n_compared++; if (rsp_id !== 2'd0 || rsp_data !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_rsp: got id %0d data %0d expected 0/0", rsp_id, rsp_data); end
        rst = 1'b0;
        #1;
        n_compared++; if (req_ready !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL first_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        n_compared++; if (alu_a !== 8'd10 || alu_sel !== 3'd1) begin n_mismatched++; $display("[TB] FAIL first_latch: got a %0d sel %0d expected 10/1", alu_a, alu_sel); end
        @(negedge clk);
        n_compared++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'd7) begin n_mismatched++; $display("[TB] FAIL first_rsp: got v %b id %0d data %0d expected 1/0/7", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL first_rsp_drop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_single();
        set_op(2, 8'd200, 8'd100, 3'd0);
        req_valid = 4'b0100;
        #1;
        n_compared++; if (req_ready !== 4'b0100) begin n_mismatched++; $display("[TB] FAIL single_grant: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        n_compared++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL single_exec: got v %b ready %b expected 0/0000", rsp_valid, req_ready); end
        n_compared++; if (alu_a !== 8'd200 || alu_b !== 8'd100 || alu_sel !== 3'd0) begin n_mismatched++; $display("[TB] FAIL single_operands: got %0d/%0d/%0d expected 200/100/0", alu_a, alu_b, alu_sel); end
        @(negedge clk);
        n_compared++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'd44) begin n_mismatched++; $display("[TB] FAIL single_rsp: got v %b id %0d data %0d expected 1/2/44", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
        n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data [4];
        logic [2:0] exp_sel  [4];
        int         id;
        exp_data[0] = 8'h03; exp_sel[0] = 3'd0;
        exp_data[1] = 8'h05; exp_sel[1] = 3'd1;
        exp_data[2] = 8'h30; exp_sel[2] = 3'd2;
        exp_data[3] = 8'hF0; exp_sel[3] = 3'd7;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_op(0, 8'd1, 8'd2, 3'd0);
        set_op(1, 8'd9, 8'd4, 3'd1);
        set_op(2, 8'hF0, 8'h3C, 3'd2);
        set_op(3, 8'h0F, 8'h30, 3'd7);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            id = g % 4;
            #1;
            n_compared++; if (req_ready !== 4'(1 << id)) begin n_mismatched++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", g, req_ready, 4'(1 << id)); end
            @(negedge clk);
            n_compared++; if (req_ready !== 4'b0000 || alu_sel !== exp_sel[id]) begin n_mismatched++; $display("[TB] FAIL rr_exec%0d: got ready %b sel %0d expected 0000/%0d", g, req_ready, alu_sel, exp_sel[id]); end
            @(negedge clk);
            n_compared++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_data !== exp_data[id]) begin n_mismatched++; $display("[TB] FAIL rr_rsp%0d: got v %b id %0d data %h expected 1/%0d/%h", g, rsp_valid, rsp_id, rsp_data, id, exp_data[id]); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        #1;
        n_compared++; if (req_ready !== 4'b0100) begin n_mismatched++; $display("[TB] FAIL bp_grant: got %b expected 0100", req_ready); end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_compared++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h30 || req_ready !== 4'b0000) begin
                n_mismatched++;
                $display("[TB] FAIL bp_hold%0d: got v %b id %0d data %h ready %b expected 1/2/30/0000", i, rsp_valid, rsp_id, rsp_data, req_ready);
            end
            if (i < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_compared++; if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin n_mismatched++; $display("[TB] FAIL bp_release: got v %b ready %b expected 0/1000", rsp_valid, req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        n_compared++; if (rsp_id !== 2'd3 || rsp_data !== 8'hF0) begin n_mismatched++; $display("[TB] FAIL bp_next_rsp: got id %0d data %h expected 3/F0", rsp_id, rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_exec();
        // Move rr_ptr to 3 first so a post-reset grant of 1 proves the pointer cleared.
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        set_op(1, 8'd50, 8'd25, 3'd1);
        req_valid = 4'b0010;
        #1;
        n_compared++; if (req_ready !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL rx_grant: got %b expected 0010", req_ready); end
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        #1;
        n_compared++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rx_in_reset: got ready %b v %b expected 0000/0", req_ready, rsp_valid); end
        n_compared++; if (alu_a !== 8'd0 || alu_sel !== 3'd0) begin n_mismatched++; $display("[TB] FAIL rx_alu_clear: got a %0d sel %0d expected 0/0", alu_a, alu_sel); end
        rst       = 1'b0;
        req_valid = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            n_compared++; if (rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rx_no_rsp: got %b expected 0", rsp_valid); end
        end
        req_valid = 4'b1010;
        #1;
        n_compared++; if (req_ready !== 4'b0010) begin n_mismatched++; $display("[TB] FAIL rx_regrant: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        n_compared++; if (alu_a !== 8'd50 || alu_b !== 8'd25) begin n_mismatched++; $display("[TB] FAIL rx_operands: got %0d/%0d expected 50/25", alu_a, alu_b); end
        @(negedge clk);
        n_compared++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'd25) begin n_mismatched++; $display("[TB] FAIL rx_rsp: got v %b id %0d data %0d expected 1/1/25", rsp_valid, rsp_id, rsp_data); end
        @(negedge clk);
    endtask

`ifdef ALU_PERF_EN
    task automatic run_op(input int id, input int stall);
        req_valid = 4'(1 << id);
        rsp_ready = (stall == 0);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_perf();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_compared++; if (perf_ops !== 16'd0) begin n_mismatched++; $display("[TB] FAIL perf_reset0: got %0d expected 0", perf_ops); end
        run_op(0, 0);
        run_op(1, 4);
        n_compared++; if (perf_ops !== 16'd2) begin n_mismatched++; $display("[TB] FAIL perf_mid: got %0d expected 2", perf_ops); end
        run_op(2, 0);
        n_compared++; if (perf_ops !== 16'd3) begin n_mismatched++; $display("[TB] FAIL perf_count: got %0d expected 3", perf_ops); end
        rst = 1'b1;
        @(negedge clk);
        n_compared++; if (perf_ops !== 16'd0) begin n_mismatched++; $display("[TB] FAIL perf_reset: got %0d expected 0", perf_ops); end
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
`ifdef ALU_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Shares one combinational 8-bit ALU between NUM_REQ requesters.
- The ALU has operands in_a and in_b, a 3-bit sel, and an output out.
- Arbitration is round-robin. Each request's operands and opcode are latched, presented to the ALU for one cycle, and the result is registered.
- The result is returned with the requester ID over a valid/ready response channel. The block sits between client engines and the single shared alu instance.

Parameters:
- WIDTH, 8, ALU operand and result width.
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i occupies [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B, same packing.
- req_sel  input  NUM_REQ*3  packed opcode; requester i occupies [i*3 +: 3].
- alu_a  output  WIDTH  drives ALU in_a.
- alu_b  output  WIDTH  drives ALU in_b.
- alu_sel  output  3  drives ALU sel.
- alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_data  output  WIDTH  registered ALU result.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rr_ptr=0, alu_a/alu_b/alu_sel=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - req_ready=0 while rst=1.
  - Reset mid-transaction drops the pending operation; no response is produced.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ... (wrap-around).
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes there.
  - On that edge, latch req_a/req_b/req_sel slice g into alu_a/alu_b/alu_sel, latch g into rsp_id, go to EXEC.
  - With no valid request: stay in IDLE, req_ready=0.
- EXEC:
  - ALU inputs held stable; req_ready=0.
  - On the edge, rsp_data <= alu_out, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data held constant while rsp_ready=0 (backpressure of any length).
  - When rsp_valid & rsp_ready: rsp_valid <= 0, rr_ptr <= (rsp_id+1) mod NUM_REQ, go to IDLE.
  - req_ready=0 throughout RESP.
- Latency and throughput:
  - Accept at cycle T gives rsp_valid=1 at T+2.
  - With rsp_ready tied high, maximum throughput is one operation per 3 cycles.
- Request rules:
  - A requester holds its valid, operands and opcode until it sees ready.
  - Changes to a non-granted requester's inputs have no effect.
- Simultaneous requests: only the round-robin winner is accepted; the others wait. No requester waits more than NUM_REQ-1 other grants.
- Opcode: req_sel is passed through unmodified; all 8 codes are legal, and code 7 is forwarded as is.
- Result is WIDTH bits exactly as returned by the ALU; no carry is captured.
- alu_a/alu_b/alu_sel keep their last granted values in IDLE and RESP; they are not zeroed.

Optional Feature:
- Macro: ALU_PERF_EN.
- Defined:
  - Adds output port perf_ops, 16 bits.
  - perf_ops increments by 1 on each response handshake (rsp_valid & rsp_ready) and saturates at 16'hFFFF.
  - Reset value 0.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, alu_a=alu_b=0, alu_sel=0; first grant after reset goes to requester 0.
- Single request, requester 2 (a=8'd200, b=8'd100, sel=3'd0), rsp_ready=1 -> req_ready=4'b0100 at T; rsp_valid=1 at T+2 with rsp_id=2 and rsp_data equal to the ALU model result for (200,100,sel 0); rsp_valid=0 at T+3.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1, one grant every 3 cycles; each rsp_id matches its grant.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_id and rsp_data stable, req_ready=0 for all requesters, no new grant until the handshake completes.
- Reset during EXEC after accepting requester 1 -> no response emitted; rr_ptr=0; the next grant with req_valid=4'b0010 goes to requester 1 without corruption.
- ALU_PERF_EN defined: complete 3 operations with one 4-cycle backpressure stall -> perf_ops=3; rst -> perf_ops=0.
